// File: rtl/palt_nios_sysid_check.sv
// Boot-time system-ID integrity checker. It reads the sysid ID and timestamp words,
// compares them with the build-time values, and reports pass/fail through a status slave.
module palt_nios_sysid_check #(
  parameter logic [31:0] EXPECTED_ID   = 32'd8,
  parameter logic [31:0] EXPECTED_TS   = 32'd1649580841,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sid_address,
  output logic        sid_read,
  input  logic [31:0] sid_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        done,
  output logic        mismatch
);

  typedef enum logic [2:0] {
    SETTLE  = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam bit         ZERO_LAT    = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LAST    = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  settle_cnt;
  logic [1:0]  lat_cnt;
  logic        id_ok;
  logic        ts_ok;
  logic [31:0] id_reg;
  logic [31:0] ts_reg;
  logic        sample_id;
  logic        sample_ts;
  logic        restart;
  logic        busy;
  logic [31:0] status_word;
  logic        unused_writedata;

  assign unused_writedata = ^s_writedata[31:1];

  // With zero latency the issue cycle is also the sample cycle.
  assign sample_id = ZERO_LAT ? (state == RD_ID)
                              : (state == WAIT_ID && lat_cnt == LAT_LAST);
  assign sample_ts = ZERO_LAT ? (state == RD_TS)
                              : (state == WAIT_TS && lat_cnt == LAT_LAST);

  assign restart = s_write && (s_address == 2'd0) && s_writedata[0] && (state == DONE);

  // State register and sequencing counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      lat_cnt    <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state      <= next_state;
      settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      lat_cnt    <= (state == WAIT_ID || state == WAIT_TS) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = RD_ID;
      RD_ID:   next_state = ZERO_LAT ? RD_TS : WAIT_ID;
      WAIT_ID: if (sample_id) next_state = RD_TS;
      RD_TS:   next_state = ZERO_LAT ? DONE : WAIT_TS;
      WAIT_TS: if (sample_ts) next_state = DONE;
      DONE:    if (restart) next_state = SETTLE;
      default: next_state = SETTLE;
    endcase
  end

  always_comb begin
    sid_read = (state == RD_ID) || (state == RD_TS);
    busy     = (state != DONE);
  end

  always_comb begin
    status_word = '0;
    case (s_address)
      2'd0:    status_word = {28'b0, busy, ts_ok, id_ok, done};
      2'd1:    status_word = id_reg;
      2'd2:    status_word = ts_reg;
      default: status_word = '0;
    endcase
  end

  // Captured words, verdict flags and the registered slave ports.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sid_address <= 1'b0;
      s_readdata  <= '0;
      done        <= 1'b0;
      mismatch    <= 1'b0;
      id_reg      <= '0;
      ts_reg      <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
    end else begin
      if (next_state == RD_ID) sid_address <= 1'b0;
      else if (next_state == RD_TS) sid_address <= 1'b1;

      if (restart) begin
        done     <= 1'b0;
        mismatch <= 1'b0;
        id_reg   <= '0;
        ts_reg   <= '0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
      end else begin
        if (sample_id) begin
          id_reg <= sid_readdata;
          id_ok  <= (sid_readdata == EXPECTED_ID);
        end
        if (sample_ts) begin
          ts_reg   <= sid_readdata;
          ts_ok    <= (sid_readdata == EXPECTED_TS);
          done     <= 1'b1;
          mismatch <= !(id_ok && (sid_readdata == EXPECTED_TS));
        end
      end

      // Reads see pre-edge status, so a same-cycle move into DONE is not reflected yet.
      if (s_read) s_readdata <= status_word;
    end
  end

endmodule

// File: doc/palt_nios_sysid_check.md
# palt_nios_sysid_check

Boot-time integrity checker that sits directly upstream of the system-ID control slave in the Nios platform. After reset it acts as a small Avalon-MM read master: it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and publishes pass/fail. The result is also exposed to the CPU through a small status slave, and the CPU can re-run the check through that slave.

## Interface
Parameters:
- EXPECTED_ID, 32'd8: required value at sysid address 0.
- EXPECTED_TS, 32'd1649580841: required value at sysid address 1.
- SETTLE_CYCLES, 16: idle cycles after reset before the first read (legal range 1..255).
- READ_LATENCY, 1: cycles from the sysid read-issue cycle to the readdata sample cycle (legal range 0..3).

Ports:
- clock, in, 1: single clock; all logic is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sid_address, out, 1: address to the sysid slave.
- sid_read, out, 1: read strobe to the sysid slave.
- sid_readdata, in, 32: read data from the sysid slave.
- s_address, in, 2: status-slave word address.
- s_read, in, 1: status-slave read strobe.
- s_write, in, 1: status-slave write strobe.
- s_writedata, in, 32: status-slave write data.
- s_readdata, out, 32: status-slave read data.
- done, out, 1: the check has completed.
- mismatch, out, 1: the check completed with at least one compare failing.

## Operation
- FSM states: SETTLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE. Reset state is SETTLE.
- SETTLE:
  - An 8-bit counter counts SETTLE_CYCLES cycles, then the FSM moves to RD_ID.
- RD_ID:
  - Drives sid_read=1 and sid_address=0 for exactly one cycle.
  - Moves to WAIT_ID, or captures in the same cycle when READ_LATENCY=0.
- WAIT_ID:
  - A latency counter counts READ_LATENCY cycles.
  - On the final cycle, the block captures sid_readdata into id_reg and sets id_ok = (sid_readdata == EXPECTED_ID).
  - Moves to RD_TS.
- RD_TS / WAIT_TS:
  - Same sequence with sid_address=1.
  - Captures into ts_reg and sets ts_ok = (sid_readdata == EXPECTED_TS).
  - Moves to DONE.
- DONE:
  - done=1 and mismatch = !(id_ok & ts_ok). Both hold until restart or reset.
- Outside RD_ID and RD_TS: sid_read=0 and sid_address holds its last value.
- Status slave map (reads):
  - addr0: {28'b0, busy, ts_ok, id_ok, done}, where busy = (state != DONE).
  - addr1: id_reg.
  - addr2: ts_reg.
  - addr3: 32'h0.
- Status slave writes:
  - A write to addr0 with s_writedata[0]=1 while in DONE restarts the check. It clears done, mismatch, id_ok, ts_ok, id_reg and ts_reg, and enters SETTLE with the counter reset.
  - A restart write while busy is ignored.
  - Writes to any other address, or with bit0=0, are ignored.
- Reset values: sid_read=0, sid_address=0, s_readdata=0, done=0, mismatch=0, id_reg=0, ts_reg=0, id_ok=0, ts_ok=0.

## Timing
- Cycle numbering: cycle 0 is the first rising edge after reset_n deasserts.
- SETTLE occupies cycles 0..S-1, where S = SETTLE_CYCLES. RD_ID is cycle S.
- Each read takes L+1 cycles, where L = READ_LATENCY: the issue cycle plus L wait cycles. The sample is taken on the last of these cycles.
- The ID sample is at cycle S+L. RD_TS is at cycle S+L+1. The TS sample is at cycle S+2L+1.
- done and mismatch are registered and first read 1 / valid at cycle S+2L+2. With defaults (S=16, L=1), that is cycle 20.
- s_readdata is registered: valid on the cycle after s_read, held otherwise. The slave has no wait states.
- If s_read to addr0 and the transition into DONE occur in the same cycle, the returned status is the pre-transition value.
- Asserting reset_n low mid-check forces all outputs to their reset values immediately (asynchronously). On release, the check restarts from SETTLE.

## Test plan
- Default parameters, slave returns 8 at address 0 and 1649580841 at address 1, L=1:
  - sid_read pulses at cycles 16 and 18 with sid_address 0 then 1.
  - done=1 and mismatch=0 at cycle 20.
  - A status read returns 32'h7.
- Slave returns 9 at address 0:
  - done=1, mismatch=1.
  - Status reads 32'h5 (ts_ok=1, id_ok=0); addr1 reads 32'd9.
- READ_LATENCY=0 and READ_LATENCY=3:
  - Captures occur exactly L cycles after each issue cycle.
  - done rises at cycle S+2 (L=0) and S+8 (L=3).
  - Changing sid_readdata one cycle off the sample point must not affect the result.
- Restart write to addr0 (bit0=1) while in DONE:
  - done, mismatch, addr1 and addr2 read 0 on the next status reads; the check re-runs and done reasserts after S+2L+2 cycles.
  - The same write issued while busy leaves the sequence timing unchanged.
- Assert reset_n during WAIT_TS:
  - All outputs go to 0 without waiting for a clock edge.
  - After release, the first sid_read pulse occurs at cycle S.
